// File: rtl/hazard_pkg.sv
// Shared types for the RV32I pipeline hazard controller: forwarding select
// encodings, memory-wait FSM states and the bundled stage-control word.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctrl_t;

  // Held during reset and the cycle after: nothing stalls, every flushable stage bubbles.
  localparam hz_ctrl_t CTRL_RESET = '{
    stall_f: 1'b0, stall_d: 1'b0, stall_e: 1'b0, stall_m: 1'b0,
    flush_d: 1'b1, flush_e: 1'b1, flush_w: 1'b1
  };

  // Every stage up to M holds while the bubble drains into W.
  localparam hz_ctrl_t CTRL_MEM_STALL = '{
    stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1, stall_m: 1'b1,
    flush_d: 1'b0, flush_e: 1'b0, flush_w: 1'b1
  };

endpackage

// File: rtl/fwd_select.sv
// Single-operand forwarding comparator: picks the youngest producer of an
// execute-stage source register, with x0 never forwarded.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_rs_e,
  input  logic [WIDTH-1:0] i_rd_m,
  input  logic [WIDTH-1:0] i_rd_w,
  input  logic             i_reg_write_m,
  input  logic             i_reg_write_w,
  output fwd_sel_t         o_sel
);

  logic w_rs_nonzero;
  logic w_hit_m;
  logic w_hit_w;

  assign w_rs_nonzero = (i_rs_e != '0);
  assign w_hit_m      = i_reg_write_m && (i_rd_m == i_rs_e);
  assign w_hit_w      = i_reg_write_w && (i_rd_w == i_rs_e);

  // NOTE: o_sel is given a value before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    o_sel = FWD_RF;
    if (w_rs_nonzero) begin
      if (w_hit_m) begin
        o_sel = FWD_MEM;
      end else if (w_hit_w) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: operand forwarding, load-use/branch stall-flush,
// memory-wait FSM with sticky timeout. Perf counters built only with HAZARD_PERF_EN.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  Rs1D,
  input  logic [WIDTH-1:0]  Rs2D,
  input  logic [WIDTH-1:0]  Rs1E,
  input  logic [WIDTH-1:0]  Rs2E,
  input  logic [WIDTH-1:0]  RdE,
  input  logic [WIDTH-1:0]  RdM,
  input  logic [WIDTH-1:0]  RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              mem_timeout_err,
  output logic [PERF_W-1:0] perf_lu,
  output logic [PERF_W-1:0] perf_mw,
  output logic [PERF_W-1:0] perf_br
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  hz_state_t        r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_rst_q;
  logic             r_tmo_err;
  logic             r_tmo_q;

  fwd_sel_t         w_fwd_a;
  fwd_sel_t         w_fwd_b;
  logic             w_rst_active;
  logic             w_lw_hazard;
  logic             w_mem_enter;
  logic             w_mem_stall;
  logic             w_lw_stall;
  logic             w_branch;
  logic             w_tmo_hit;
  logic [CNT_W-1:0] w_cnt_next;
  hz_ctrl_t         w_ctrl;

  fwd_select #(.WIDTH(WIDTH)) u_fwd_a (
    .i_rs_e        (Rs1E),
    .i_rd_m        (RdM),
    .i_rd_w        (RdW),
    .i_reg_write_m (RegWriteM),
    .i_reg_write_w (RegWriteW),
    .o_sel         (w_fwd_a)
  );

  fwd_select #(.WIDTH(WIDTH)) u_fwd_b (
    .i_rs_e        (Rs2E),
    .i_rd_m        (RdM),
    .i_rd_w        (RdW),
    .i_reg_write_m (RegWriteM),
    .i_reg_write_w (RegWriteW),
    .o_sel         (w_fwd_b)
  );

  // Reset outputs persist one cycle past rst so the first fetch sees bubbled stages.
  assign w_rst_active = rst || r_rst_q;

  assign w_lw_hazard = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // The cycle right after a timeout never re-enters the wait, so the stuck access leaves M.
  assign w_mem_enter = (r_state == RUN) && MemReqM && !MemReadyM && !r_tmo_q && !w_rst_active;
  assign w_mem_stall = ((r_state == MEM_WAIT) || w_mem_enter) && !w_rst_active;

  assign w_lw_stall = w_lw_hazard && !w_mem_stall && !w_rst_active;
  assign w_branch   = PCSrcE && !w_mem_stall && !w_rst_active;

  assign w_cnt_next = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);
  assign w_tmo_hit  = (r_state == MEM_WAIT) && !MemReadyM && (w_cnt_next == CNT_MAX);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_rst_q    <= 1'b1;
      r_tmo_err  <= 1'b0;
      r_tmo_q    <= 1'b0;
    end else begin
      r_rst_q <= 1'b0;
      r_tmo_q <= 1'b0;
      case (r_state)
        RUN: begin
          r_wait_cnt <= '0;
          if (w_mem_enter) begin
            r_state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          r_wait_cnt <= w_cnt_next;
          if (MemReadyM) begin
            r_state <= RUN;
          end else if (w_tmo_hit) begin
            r_state   <= RUN;
            r_tmo_err <= 1'b1;
            r_tmo_q   <= 1'b1;
          end
        end
        default: begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // Priority: reset, then memory stall (masks load-use and branch), then normal hazards.
  always_comb begin
    w_ctrl = '0;
    if (w_rst_active) begin
      w_ctrl = CTRL_RESET;
    end else if (w_mem_stall) begin
      w_ctrl = CTRL_MEM_STALL;
    end else begin
      w_ctrl.stall_f = w_lw_stall;
      w_ctrl.stall_d = w_lw_stall;
      w_ctrl.flush_d = w_branch;
      w_ctrl.flush_e = w_lw_stall || w_branch;
    end
  end

  assign ForwardAE = w_rst_active ? FWD_RF : w_fwd_a;
  assign ForwardBE = w_rst_active ? FWD_RF : w_fwd_b;

  assign StallF = w_ctrl.stall_f;
  assign StallD = w_ctrl.stall_d;
  assign StallE = w_ctrl.stall_e;
  assign StallM = w_ctrl.stall_m;
  assign FlushD = w_ctrl.flush_d;
  assign FlushE = w_ctrl.flush_e;
  assign FlushW = w_ctrl.flush_w;

  assign mem_timeout_err = r_tmo_err && !rst;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] r_perf_lu;
  logic [PERF_W-1:0] r_perf_mw;
  logic [PERF_W-1:0] r_perf_br;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_lu <= '0;
      r_perf_mw <= '0;
      r_perf_br <= '0;
    end else begin
      if (w_lw_stall) r_perf_lu <= r_perf_lu + PERF_W'(1);
      if (w_mem_stall) r_perf_mw <= r_perf_mw + PERF_W'(1);
      if (w_branch) r_perf_br <= r_perf_br + PERF_W'(1);
    end
  end

  assign perf_lu = rst ? '0 : r_perf_lu;
  assign perf_mw = rst ? '0 : r_perf_mw;
  assign perf_br = rst ? '0 : r_perf_br;
`else
  assign perf_lu = '0;
  assign perf_mw = '0;
  assign perf_br = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a table of single-cycle vectors plus
// multi-cycle sequences, all checked through an expected-output scoreboard.
module tb_hazard_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic        mem_timeout_err;
  logic [31:0] perf_lu, perf_mw, perf_br;

  hazard_unit #(.WIDTH(5), .MEM_TIMEOUT(16), .PERF_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .Rs1D            (Rs1D),
    .Rs2D            (Rs2D),
    .Rs1E            (Rs1E),
    .Rs2E            (Rs2E),
    .RdE             (RdE),
    .RdM             (RdM),
    .RdW             (RdW),
    .RegWriteM       (RegWriteM),
    .RegWriteW       (RegWriteW),
    .ResultSrcE0     (ResultSrcE0),
    .PCSrcE          (PCSrcE),
    .MemReqM         (MemReqM),
    .MemReadyM       (MemReadyM),
    .ForwardAE       (ForwardAE),
    .ForwardBE       (ForwardBE),
    .StallF          (StallF),
    .StallD          (StallD),
    .StallE          (StallE),
    .StallM          (StallM),
    .FlushD          (FlushD),
    .FlushE          (FlushE),
    .FlushW          (FlushW),
    .mem_timeout_err (mem_timeout_err),
    .perf_lu         (perf_lu),
    .perf_mw         (perf_mw),
    .perf_br         (perf_br)
  );

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, lde, pcs, mreq, mrdy, rst;
  } in_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic       sf, sd, se, sm, fd, fe, fw, err;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  typedef struct {
    string name;
    out_t  exp;
  } sb_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  sb_t  exp_q[$];
  vec_t tv[$];
  sb_t  mon_e;
  out_t mon_act;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic in_t mkin(int rs1d, int rs2d, int rs1e, int rs2e, int rde, int rdm, int rdw,
                               logic rwm, logic rww, logic lde, logic pcs, logic mreq, logic mrdy);
    in_t r;
    r.rs1d = 5'(rs1d); r.rs2d = 5'(rs2d); r.rs1e = 5'(rs1e); r.rs2e = 5'(rs2e);
    r.rde = 5'(rde); r.rdm = 5'(rdm); r.rdw = 5'(rdw);
    r.rwm = rwm; r.rww = rww; r.lde = lde; r.pcs = pcs; r.mreq = mreq; r.mrdy = mrdy;
    r.rst = 1'b0;
    return r;
  endfunction

  function automatic out_t mkout(int fa, int fb, logic sf, logic sd, logic se, logic sm,
                                 logic fd, logic fe, logic fw, logic err);
    out_t r;
    r.fa = 2'(fa); r.fb = 2'(fb);
    r.sf = sf; r.sd = sd; r.se = se; r.sm = sm;
    r.fd = fd; r.fe = fe; r.fw = fw; r.err = err;
    return r;
  endfunction

  // Drive one cycle of stimulus just after the edge and queue what it must produce.
  task automatic apply(input string name, input in_t in, input out_t exp);
    sb_t e;
    @(posedge clk);
    #1;
    rst = in.rst;
    Rs1D = in.rs1d; Rs2D = in.rs2d; Rs1E = in.rs1e; Rs2E = in.rs2e;
    RdE = in.rde; RdM = in.rdm; RdW = in.rdw;
    RegWriteM = in.rwm; RegWriteW = in.rww; ResultSrcE0 = in.lde;
    PCSrcE = in.pcs; MemReqM = in.mreq; MemReadyM = in.mrdy;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                 mem_timeout_err};
      check(mon_e.name, 32'(mon_act), 32'(mon_e.exp));
    end
  end

  initial begin
    in_t  idle_i, rst_i, cur;
    out_t rst_o, idle_o, mem_o, idle_err_o, mem_err_o;

    rst = 1'b1;
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0;

    idle_i     = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_i      = idle_i;
    rst_i.rst  = 1'b1;
    rst_o      = mkout(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    idle_o     = mkout(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_o      = mkout(0, 0, 1, 1, 1, 1, 0, 0, 1, 0);
    idle_err_o = mkout(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    mem_err_o  = mkout(0, 0, 1, 1, 1, 1, 0, 0, 1, 1);

    tv.push_back('{"fwd_a_m_priority", mkin(0,0,5,0,0,5,5,1,1,0,0,0,0), mkout(2,0,0,0,0,0,0,0,0,0)});
    tv.push_back('{"fwd_a_wb",         mkin(0,0,5,0,0,5,5,0,1,0,0,0,0), mkout(1,0,0,0,0,0,0,0,0,0)});
    tv.push_back('{"fwd_a_rs_zero",    mkin(0,0,0,0,0,5,5,1,1,0,0,0,0), idle_o});
    tv.push_back('{"fwd_x0_never",     mkin(0,0,0,0,0,0,0,1,1,0,0,0,0), idle_o});
    tv.push_back('{"fwd_b_m",          mkin(0,0,0,9,0,9,0,1,0,0,0,0,0), mkout(0,2,0,0,0,0,0,0,0,0)});
    tv.push_back('{"fwd_b_wb",         mkin(0,0,0,9,0,3,9,1,1,0,0,0,0), mkout(0,1,0,0,0,0,0,0,0,0)});
    tv.push_back('{"fwd_both",         mkin(0,0,4,6,0,6,4,1,1,0,0,0,0), mkout(1,2,0,0,0,0,0,0,0,0)});
    tv.push_back('{"fwd_no_write",     mkin(0,0,5,5,0,5,5,0,0,0,0,0,0), idle_o});
    tv.push_back('{"lu_rs2",           mkin(0,7,0,0,7,0,0,0,0,1,0,0,0), mkout(0,0,1,1,0,0,0,1,0,0)});
    tv.push_back('{"lu_clears",        mkin(0,7,0,0,7,0,0,0,0,0,0,0,0), idle_o});
    tv.push_back('{"lu_rde_zero",      mkin(0,7,0,0,0,0,0,0,0,1,0,0,0), idle_o});
    tv.push_back('{"lu_all_zero",      mkin(0,0,0,0,0,0,0,0,0,1,0,0,0), idle_o});
    tv.push_back('{"lu_rs1_fwd",       mkin(3,0,5,0,3,5,0,1,0,1,0,0,0), mkout(2,0,1,1,0,0,0,1,0,0)});
    tv.push_back('{"not_load",         mkin(3,0,0,0,3,0,0,0,0,0,0,0,0), idle_o});
    tv.push_back('{"branch",           mkin(0,0,0,0,0,0,0,0,0,0,1,0,0), mkout(0,0,0,0,0,0,1,1,0,0)});
    tv.push_back('{"branch_and_lu",    mkin(0,7,0,0,7,0,0,0,0,1,1,0,0), mkout(0,0,1,1,0,0,1,1,0,0)});
    tv.push_back('{"mem_ready_now",    mkin(0,0,0,0,0,0,0,0,0,0,0,1,1), idle_o});

    // Power-on reset: two cycles in rst, then one trailing reset cycle.
    apply("rst_hold0", rst_i, rst_o);
    apply("rst_hold1", rst_i, rst_o);
    apply("rst_after", idle_i, rst_o);

    foreach (tv[i]) apply(tv[i].name, tv[i].in, tv[i].exp);
    drain();

    // Memory wait: ready low three cycles then high gives four stalled cycles.
    apply("mw_rst", rst_i, rst_o);
    apply("mw_rst_after", idle_i, rst_o);
    cur = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply("mw_enter", cur, mem_o);
    apply("mw_masked", mkin(0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, 1, 0), mem_o);
    apply("mw_wait", cur, mem_o);
    cur.mrdy = 1'b1;
    apply("mw_ready_cycle", cur, mem_o);
    apply("mw_pending_br", mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), mkout(0,0,0,0,0,0,1,1,0,0));
    apply("mw_idle", idle_i, idle_o);
    drain();
    @(posedge clk);
    #1;
`ifdef HAZARD_PERF_EN
    check("perf_mw_after_wait", perf_mw, 32'd4);
    check("perf_br_after_wait", perf_br, 32'd1);
    check("perf_lu_after_wait", perf_lu, 32'd0);
`else
    check("perf_mw_tied", perf_mw, 32'd0);
    check("perf_br_tied", perf_br, 32'd0);
    check("perf_lu_tied", perf_lu, 32'd0);
`endif

    // Timeout: entry cycle plus 16 wait cycles stall, then the flag sets and the stall drops.
    cur = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 17; i++) apply($sformatf("tmo_stall%0d", i), cur, mem_o);
    apply("tmo_released", cur, idle_err_o);
    apply("tmo_sticky0", idle_i, idle_err_o);
    apply("tmo_sticky1", idle_i, idle_err_o);

    // Reset in the middle of a wait, with forwarding inputs live throughout.
    cur = mkin(0, 0, 5, 0, 0, 5, 0, 1, 0, 0, 0, 1, 0);
    apply("rmw_enter", cur, mkout(2,0,1,1,1,1,0,0,1,1));
    apply("rmw_wait", cur, mkout(2,0,1,1,1,1,0,0,1,1));
    cur.rst = 1'b1;
    apply("rmw_rst", cur, rst_o);
    cur.rst = 1'b0;
    apply("rmw_rst_after", cur, rst_o);
    apply("rmw_reenter", cur, mkout(2,0,1,1,1,1,0,0,1,0));
    cur.mrdy = 1'b1;
    apply("rmw_ready", cur, mkout(2,0,1,1,1,1,0,0,1,0));
    cur.mreq = 1'b0;
    cur.mrdy = 1'b0;
    apply("rmw_run", cur, mkout(2,0,0,0,0,0,0,0,0,0));
    drain();
    @(posedge clk);
    #1;
`ifdef HAZARD_PERF_EN
    check("perf_mw_after_rst", perf_mw, 32'd2);
`else
    check("perf_mw_after_rst", perf_mw, 32'd0);
`endif
    check("err_cleared", 32'(mem_timeout_err), 32'd0);

    // Unused outputs stay constant; mem_err_o kept for symmetry of the expected set.
    if (mem_err_o.err !== 1'b1) n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
